// File: rtl/motor_ramp_ctrl.sv
// Multi-channel H-bridge controller: slew-limited duty, safe reversal, immediate brake.
// Optional period watchdog enabled by defining MOTOR_WATCHDOG_EN.
module motor_ramp_ctrl #(
  parameter int unsigned CH           = 2,
  parameter int unsigned DUTY_W       = 10,
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned PWM_HZ       = 25_000,
  parameter int unsigned RAMP_STEP    = 32,
  parameter int unsigned DEAD_PERIODS = 4,
  parameter int unsigned WDOG_PERIODS = 2500
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] cmd_ch,
  input  logic [1:0]                            cmd_dir,
  input  logic [DUTY_W-1:0]                     cmd_speed,
  output logic [CH-1:0]                         pwm,
  output logic [2*CH-1:0]                       motor_in,
  output logic [CH-1:0]                         busy,
  output logic                                  period_tick
);

  localparam int unsigned PERIOD = CLK_HZ / PWM_HZ;
  localparam int unsigned CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned DCNT_W = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;

  localparam logic [1:0] DirCoast = 2'b00;
  localparam logic [1:0] DirFwd   = 2'b01;
  localparam logic [1:0] DirRev   = 2'b10;
  localparam logic [1:0] DirBrake = 2'b11;

  typedef enum logic [2:0] {StCoast, StRun, StDown, StDead, StBrake} state_e;

  logic [CNT_W-1:0] cnt_q;
  logic             tick;
  logic             accept;
  logic             wdog_fire;

  state_e              state_q [CH];
  state_e              state_d [CH];
  logic [1:0]          dir_q   [CH];
  logic [1:0]          dir_d   [CH];
  logic [1:0]          tdir_q  [CH];
  logic [1:0]          tdir_d  [CH];
  logic [DUTY_W-1:0]   tspd_q  [CH];
  logic [DUTY_W-1:0]   tspd_d  [CH];
  logic [DUTY_W-1:0]   duty_q  [CH];
  logic [DUTY_W-1:0]   duty_d  [CH];
  logic [DCNT_W-1:0]   dcnt_q  [CH];
  logic [DCNT_W-1:0]   dcnt_d  [CH];
  logic [CNT_W-1:0]    thr_q   [CH];
  logic [CNT_W-1:0]    thr_d   [CH];

  logic [CH-1:0]       pwm_q, pwm_d;
  logic [CH-1:0]       busy_q, busy_d;
  logic [2*CH-1:0]     motor_in_q, motor_in_d;

  assign tick        = (cnt_q == CNT_W'(PERIOD - 1));
  assign period_tick = tick;
  assign cmd_ready   = rst;
  assign accept      = cmd_valid && cmd_ready;

  assign pwm      = pwm_q;
  assign busy     = busy_q;
  assign motor_in = motor_in_q;

`ifdef MOTOR_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WDOG_PERIODS + 1);

  logic [WD_W-1:0] wdog_q;

  // Counter saturates at the timeout so the coast retarget fires only once.
  assign wdog_fire = tick && !accept && (wdog_q == WD_W'(WDOG_PERIODS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q <= '0;
    end else if (accept) begin
      wdog_q <= '0;
    end else if (tick && (wdog_q != WD_W'(WDOG_PERIODS))) begin
      wdog_q <= wdog_q + WD_W'(1);
    end
  end
`else
  assign wdog_fire = 1'b0;
`endif

  function automatic logic [DUTY_W-1:0] ramp_to(input logic [DUTY_W-1:0] cur,
                                                input logic [DUTY_W-1:0] tgt);
    logic [31:0] c32;
    logic [31:0] t32;
    c32 = 32'(cur);
    t32 = 32'(tgt);
    if (t32 > c32 + RAMP_STEP) return DUTY_W'(c32 + RAMP_STEP);
    if (c32 > t32 + RAMP_STEP) return DUTY_W'(c32 - RAMP_STEP);
    return tgt;
  endfunction

  function automatic logic [DUTY_W-1:0] ramp_down(input logic [DUTY_W-1:0] cur);
    logic [31:0] c32;
    c32 = 32'(cur);
    if (c32 > RAMP_STEP) return DUTY_W'(c32 - RAMP_STEP);
    return '0;
  endfunction

  // Full-width product so large PERIOD values cannot overflow before the shift.
  function automatic logic [CNT_W-1:0] thr_of(input logic [DUTY_W-1:0] d);
    logic [63:0] prod;
    prod = 64'(PERIOD) * 64'(d);
    return CNT_W'(prod >> DUTY_W);
  endfunction

  function automatic logic [1:0] drive_of(input state_e st, input logic [1:0] dir);
    case (st)
      StRun, StDown: return (dir == DirRev) ? 2'b01 : 2'b10;
      StBrake:       return 2'b11;
      default:       return 2'b00;
    endcase
  endfunction

  function automatic logic is_move(input logic [1:0] dir);
    return (dir == DirFwd) || (dir == DirRev);
  endfunction

  always_comb begin
    pwm_d      = '0;
    busy_d     = '0;
    motor_in_d = '0;
    for (int c = 0; c < CH; c++) begin
      state_d[c] = state_q[c];
      dir_d[c]   = dir_q[c];
      tdir_d[c]  = tdir_q[c];
      tspd_d[c]  = tspd_q[c];
      duty_d[c]  = duty_q[c];
      dcnt_d[c]  = dcnt_q[c];
      thr_d[c]   = thr_q[c];
      pwm_d[c]   = (cnt_q < thr_q[c]);

      if (tick) begin
        case (state_q[c])
          StCoast: begin
            if (is_move(tdir_q[c])) begin
              state_d[c] = StRun;
              dir_d[c]   = tdir_q[c];
            end
          end
          StRun: begin
            if (tdir_q[c] == dir_q[c]) duty_d[c] = ramp_to(duty_q[c], tspd_q[c]);
            else                       state_d[c] = StDown;
          end
          StDown: begin
            if (duty_q[c] != '0) begin
              duty_d[c] = ramp_down(duty_q[c]);
            end else if (tdir_q[c] == dir_q[c]) begin
              state_d[c] = StRun;
            end else if (is_move(tdir_q[c])) begin
              state_d[c] = StDead;
              dcnt_d[c]  = '0;
            end else begin
              state_d[c] = StCoast;
            end
          end
          StDead: begin
            if (dcnt_q[c] == DCNT_W'(DEAD_PERIODS - 1)) begin
              if (is_move(tdir_q[c])) begin
                state_d[c] = StRun;
                dir_d[c]   = tdir_q[c];
              end else begin
                state_d[c] = StCoast;
              end
            end else begin
              dcnt_d[c] = dcnt_q[c] + DCNT_W'(1);
            end
          end
          StBrake: begin
            if (is_move(tdir_q[c])) begin
              state_d[c] = StRun;
              dir_d[c]   = tdir_q[c];
              duty_d[c]  = '0;
            end else if (tdir_q[c] == DirCoast) begin
              state_d[c] = StCoast;
            end
          end
          default: state_d[c] = StCoast;
        endcase
        thr_d[c] = thr_of(duty_d[c]);
      end

      if (wdog_fire) begin
        tdir_d[c] = DirCoast;
        tspd_d[c] = '0;
      end

      if (accept && (int'(cmd_ch) == c)) begin
        tdir_d[c] = cmd_dir;
        tspd_d[c] = cmd_speed;
        // Brake bypasses the ramp and silences the PWM on the very next cycle.
        if (cmd_dir == DirBrake) begin
          state_d[c] = StBrake;
          duty_d[c]  = '0;
          thr_d[c]   = '0;
          pwm_d[c]   = 1'b0;
        end
      end

      motor_in_d[2*c +: 2] = drive_of(state_d[c], dir_d[c]);
      busy_d[c] = (state_d[c] == StDown) || (state_d[c] == StDead) ||
                  (duty_d[c] != (is_move(tdir_d[c]) ? tspd_d[c] : '0));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      pwm_q      <= '0;
      busy_q     <= '0;
      motor_in_q <= '0;
      for (int c = 0; c < CH; c++) begin
        state_q[c] <= StCoast;
        dir_q[c]   <= DirCoast;
        tdir_q[c]  <= DirCoast;
        tspd_q[c]  <= '0;
        duty_q[c]  <= '0;
        dcnt_q[c]  <= '0;
        thr_q[c]   <= '0;
      end
    end else begin
      cnt_q      <= tick ? '0 : cnt_q + CNT_W'(1);
      pwm_q      <= pwm_d;
      busy_q     <= busy_d;
      motor_in_q <= motor_in_d;
      for (int c = 0; c < CH; c++) begin
        state_q[c] <= state_d[c];
        dir_q[c]   <= dir_d[c];
        tdir_q[c]  <= tdir_d[c];
        tspd_q[c]  <= tspd_d[c];
        duty_q[c]  <= duty_d[c];
        dcnt_q[c]  <= dcnt_d[c];
        thr_q[c]   <= thr_d[c];
      end
    end
  end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Scoreboarded bench for motor_ramp_ctrl: per-period IN pair, PWM high count and busy.
module tb_motor_ramp_ctrl;
  localparam int unsigned CH     = 3;
  localparam int unsigned DUTY_W = 10;
  localparam int unsigned PERIOD = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_ch = '0;
  logic [1:0]        cmd_dir = '0;
  logic [DUTY_W-1:0] cmd_speed = '0;
  logic [CH-1:0]     pwm;
  logic [2*CH-1:0]   motor_in;
  logic [CH-1:0]     busy;
  logic              period_tick;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int ch;
    int mi;
    int pw;
    int bz;
  } exp_t;

  exp_t exp_q[$];

  motor_ramp_ctrl #(
    .CH          (CH),
    .DUTY_W      (DUTY_W),
    .CLK_HZ      (1000),
    .PWM_HZ      (100),
    .RAMP_STEP   (256),
    .DEAD_PERIODS(2),
    .WDOG_PERIODS(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_ch     (cmd_ch),
    .cmd_dir    (cmd_dir),
    .cmd_speed  (cmd_speed),
    .pwm        (pwm),
    .motor_in   (motor_in),
    .busy       (busy),
    .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: a period's PWM window is the samples at cnt=1..PERIOD-1 plus cnt=0 of the next.
  int              acc [CH];
  logic            tick_seen;
  logic [2*CH-1:0] mi_s;
  logic [CH-1:0]   busy_s;

  initial begin
    exp_t e;
    tick_seen = 1'b0;
    mi_s      = '0;
    busy_s    = '0;
    for (int c = 0; c < CH; c++) acc[c] = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        tick_seen = 1'b0;
        for (int c = 0; c < CH; c++) acc[c] = 0;
      end else begin
        if (tick_seen) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("sb_in_ch%0d", e.ch), int'(mi_s[2*e.ch +: 2]), e.mi);
            check($sformatf("sb_pwm_ch%0d", e.ch), acc[e.ch] + int'(pwm[e.ch]), e.pw);
            check($sformatf("sb_busy_ch%0d", e.ch), int'(busy_s[e.ch]), e.bz);
          end
          for (int c = 0; c < CH; c++) acc[c] = 0;
        end else begin
          for (int c = 0; c < CH; c++) acc[c] += int'(pwm[c]);
        end
        tick_seen = period_tick;
        if (period_tick) begin
          mi_s   = motor_in;
          busy_s = busy;
        end
      end
    end
  end

  // Returns at the negedge of the first cycle (cnt=0) of a fresh period.
  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_tick && n < 3 * PERIOD);
    check("tick_seen", int'(period_tick), 1);
    @(negedge clk);
  endtask

  task automatic send(input int ch, input int dir, input int spd);
    cmd_valid = 1'b1;
    cmd_ch    = 2'(ch);
    cmd_dir   = 2'(dir);
    cmd_speed = DUTY_W'(spd);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic issue(input int ch, input int dir, input int spd, input int off);
    wait_tick();
    repeat (off) @(negedge clk);
    send(ch, dir, spd);
  endtask

  task automatic push(input int ch, input int mi, input int duty, input int bz);
    exp_t e;
    e.ch = ch;
    e.mi = mi;
    e.pw = (PERIOD * duty) >> DUTY_W;
    e.bz = bz;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 30 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    check("sb_drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int hi;
    int n;
    repeat (3) @(negedge clk);
    check("rst_pwm", int'(pwm), 0);
    check("rst_motor_in", int'(motor_in), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_tick", int'(period_tick), 0);
    check("rst_ready", int'(cmd_ready), 0);
    rst = 1'b1;
    @(negedge clk);
    check("ready", int'(cmd_ready), 1);

`ifndef MOTOR_WATCHDOG_EN
    // Ramp up from coast.
    issue(0, 1, 1023, 0);
    push(0, 0, 0, 1);   push(0, 2, 0, 1);   push(0, 2, 256, 1); push(0, 2, 512, 1);
    push(0, 2, 768, 1); push(0, 2, 1023, 0); push(0, 2, 1023, 0);
    drain();

    // Ramp down within the same direction.
    issue(0, 1, 512, 0);
    push(0, 2, 1023, 1); push(0, 2, 767, 1); push(0, 2, 512, 0);
    drain();

    // Reversal: down, dead time, switch, ramp.
    issue(0, 2, 512, 0);
    push(0, 2, 512, 0); push(0, 2, 512, 1); push(0, 2, 256, 1); push(0, 2, 0, 1);
    push(0, 0, 0, 1);   push(0, 0, 0, 1);   push(0, 1, 0, 1);   push(0, 1, 256, 1);
    push(0, 1, 512, 0);
    drain();

    // Brake mid-period.
    issue(1, 1, 768, 0);
    push(1, 0, 0, 1); push(1, 2, 0, 1); push(1, 2, 256, 1); push(1, 2, 512, 1);
    push(1, 2, 768, 0);
    drain();
    wait_tick();
    repeat (4) @(negedge clk);
    check("pre_brake_pwm1", int'(pwm[1]), 1);
    send(1, 3, 0);
    check("brake_in1", int'(motor_in[3:2]), 3);
    check("brake_pwm1", int'(pwm[1]), 0);
    check("brake_busy1", int'(busy[1]), 0);
    hi = 0;
    repeat (3 * PERIOD) begin
      @(negedge clk);
      hi += int'(pwm[1]);
    end
    check("brake_pwm1_low", hi, 0);
    check("brake_in1_hold", int'(motor_in[3:2]), 3);

    // Last command in a period wins; out-of-range channel ignored.
    issue(2, 1, 100, 0);
    send(2, 1, 300);
    send(3, 1, 1023);
    push(2, 0, 0, 1); push(2, 2, 0, 1); push(2, 2, 256, 1); push(2, 2, 300, 0);
    push(2, 2, 300, 0);
    drain();
    check("other_channels", int'(motor_in), 6'b10_11_01);

    // Asynchronous reset mid-ramp.
    issue(0, 1, 1023, 0);
    wait_tick();
    repeat (5) @(negedge clk);
    check("pre_rst_pwm0", int'(pwm[0]), 1);
    #2 rst = 1'b0;
    #1;
    check("arst_pwm", int'(pwm), 0);
    check("arst_motor_in", int'(motor_in), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_tick", int'(period_tick), 0);
    check("arst_ready", int'(cmd_ready), 0);
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_tick && n < 3 * PERIOD);
    check("cnt_restart", n, PERIOD - 1);

    // Target persists with no watchdog.
    issue(0, 1, 512, 0);
    push(0, 0, 0, 1); push(0, 2, 0, 1); push(0, 2, 256, 1); push(0, 2, 512, 0);
    for (int i = 0; i < 6; i++) push(0, 2, 512, 0);
    drain();
    check("post_rst_ch12", int'(motor_in[5:2]), 0);
`else
    // Watchdog retargets to coast after three silent periods.
    issue(0, 1, 512, 0);
    push(0, 0, 0, 1);   push(0, 2, 0, 1);   push(0, 2, 256, 1); push(0, 2, 512, 1);
    push(0, 2, 512, 1); push(0, 2, 256, 1); push(0, 2, 0, 1);   push(0, 0, 0, 0);
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d checks, expected completion", checks);
    $fatal(1);
  end

endmodule

// File: doc/motor_ramp_ctrl.md
Name: motor_ramp_ctrl

Overview:
Multi-channel H-bridge motor controller, successor to the fixed two-motor, mode-driven driver. Per channel: commanded direction and speed, slew-limited (ramped) duty updates at PWM period boundaries, and a safe reversal sequence (ramp down, dead time, switch). Sits between the car-control FSM (command source) and the PMOD motor driver pins (pwm plus IN pairs).

Parameters:
CH, 2, number of motor channels (1..8)
DUTY_W, 10, duty/speed width; full scale = 2^DUTY_W
CLK_HZ, 100_000_000, clk frequency in Hz
PWM_HZ, 25_000, PWM frequency; PERIOD = CLK_HZ/PWM_HZ clk cycles (integer, >=2)
RAMP_STEP, 32, max duty change per PWM period
DEAD_PERIODS, 4, PWM periods with IN=00 between direction changes (>=1)
WDOG_PERIODS, 2500, watchdog timeout in PWM periods (optional feature only)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
cmd_valid  in  1  command strobe
cmd_ready  out  1  command accept; 0 while rst low, 1 otherwise
cmd_ch  in  max(1,$clog2(CH))  target channel
cmd_dir  in  2  00 coast, 01 forward, 10 reverse, 11 brake
cmd_speed  in  DUTY_W  target duty
pwm  out  CH  PWM output, one bit per channel
motor_in  out  2*CH  IN pair per channel, [2c+1:2c]; forward 10, reverse 01, coast 00, brake 11
busy  out  CH  channel not yet settled at its target
period_tick  out  1  one-cycle pulse on the last cycle of each PWM period

Behaviour:
- Reset (rst=0, async): cnt=0, pwm=0, motor_in=0, busy=0, period_tick=0, every duty/threshold/target=0, every channel state COAST, target dir coast.
- Period counter: cnt runs 0..PERIOD-1 and wraps. period_tick=1 when cnt==PERIOD-1.
- Threshold: thr[c] = (PERIOD*duty[c])>>DUTY_W, computed at full width with no overflow. Registered at period_tick; used from cnt=0 of the next period.
- pwm[c] registered: pwm[c] <= (cnt < thr[c]). Duty 0 gives constant low. Duty changes never alter the current period.
- Command: accepted when cmd_valid&&cmd_ready. Latches target dir/speed of cmd_ch on that edge. Several commands in one period: the last one wins. cmd_ch>=CH is accepted and ignored.
- Per-channel FSM, evaluated on period_tick except where noted:
  COAST: motor_in=00, duty=0. Target fwd/rev: set dir, go RUN.
  RUN: motor_in per dir.
    Target dir equals current dir: duty moves toward target speed by min(RAMP_STEP, |diff|), saturating with no over/undershoot.
    Target is the opposite dir or coast: go DOWN.
  DOWN: duty -= min(RAMP_STEP, duty), motor_in still per old dir. When duty reaches 0:
    target coast: go COAST.
    target opposite dir: go DEAD with dcnt=0.
    target back to the old dir: go RUN.
  DEAD: motor_in=00, duty=0. dcnt increments per tick. At dcnt==DEAD_PERIODS-1, adopt the target dir and go RUN; ramping starts on the next tick.
  BRAKE: motor_in=11, duty=0. Target fwd/rev: go RUN from duty 0. Target coast: go COAST.
  Brake command from any state: on the cycle after accept, motor_in=11, duty=0, thr=0, state BRAKE. Brake is not ramped.
  A new command in any state only retargets; an in-progress DOWN/DEAD sequence completes before a new dir is adopted.
- busy[c] = state in {DOWN, DEAD} or duty[c]!=target speed, with coast/brake targets counting as speed 0.
- Reset mid-operation: all outputs return to reset values immediately (async).

Optional Feature:
MOTOR_WATCHDOG_EN.
- Defined: a counter of PWM periods clears on any accepted command. Reaching WDOG_PERIODS sets every channel's target to coast/0; channels ramp down normally. The counter then holds until the next command.
- Undefined: no watchdog logic; targets persist indefinitely.

Test Plan:
Settings unless noted: CLK_HZ=1000, PWM_HZ=100 (PERIOD=10), DUTY_W=10, RAMP_STEP=256, DEAD_PERIODS=2, CH=2.
1. Reset, then cmd ch0 fwd 1023 -> motor_in[1:0]=10. Duty per tick 256,512,768,1023. Per-period pwm high counts 2,5,7,9. busy[0] drops with duty 1023.
2. ch0 fwd at 512, cmd rev 512 -> duty 256,0 with IN=10; then 2 periods IN=00, pwm low; then IN=01, duty 256,512.
3. ch1 fwd at 768, cmd brake -> next cycle motor_in[3:2]=11, pwm[1]=0 from the next cycle onward. busy[1]=0.
4. Two commands in one period (ch0 fwd 100, then ch0 fwd 300); cmd ch=3 with CH=3 build -> target 300; ch=3 command has no effect.
5. rst low mid-ramp (cnt=5) -> pwm, motor_in, busy, period_tick all 0 asynchronously. After release, cnt restarts at 0.
6. MOTOR_WATCHDOG_EN, WDOG_PERIODS=3, ch0 fwd 512 then silence -> after 3 ticks target coast; duty 256,0, then IN=00.
